// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller and its signature register.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    // x^3+x+1, shared by the pattern generator and the MISR
    localparam logic [2:0] DEFAULT_POLY = 3'b011;
    localparam logic [2:0] DEFAULT_SEED = 3'b001;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift with polynomial feedback, then fold in the response.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
    endfunction

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_controller.sv
// Logic BIST sequencer: clears the pattern generator, drives N_PATTERNS patterns into the CUT,
// compacts the (latency-delayed) responses in a MISR and compares the signature against GOLDEN.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               WIDTH      = 3,
    parameter int               N_PATTERNS = 7,
    parameter int               CUT_LAT    = 0,
    parameter logic [WIDTH-1:0] POLY       = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] GOLDEN     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tpg_data,
    input  logic [WIDTH-1:0] cut_response,
    output logic             tpg_clear,
    output logic             test_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int               CNT_W      = $clog2(N_PATTERNS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [1:0]       DRAIN_LAST = (CUT_LAT > 0) ? 2'(CUT_LAT - 1) : 2'd0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       drain_q, drain_d;
    logic             tpg_clear_q, tpg_clear_d;
    logic             test_sel_q, test_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             run_now;
    logic             cap_en;
    logic             misr_clear;
    logic [WIDTH-1:0] sig_w;

    // The controller never looks at the patterns themselves; they go straight to the CUT.
    logic unused_tpg;
    assign unused_tpg = ^tpg_data;

    assign run_now    = (state_q == S_RUN);
    assign misr_clear = (state_q == S_CLEAR);

    // Capture window trails the RUN window by CUT_LAT cycles so each response meets its pattern.
    generate
        if (CUT_LAT == 0) begin : g_cap_direct
            assign cap_en = run_now;
        end else begin : g_cap_delayed
            logic [CUT_LAT-1:0] run_vld_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    run_vld_q <= '0;
                end else if (abort) begin
                    run_vld_q <= '0;
                end else begin
                    run_vld_q <= (run_vld_q << 1) | CUT_LAT'(run_now);
                end
            end
            assign cap_en = run_vld_q[CUT_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                cnt_d   = '0;
                drain_d = '0;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = (CUT_LAT == 0) ? S_COMPARE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            drain_d = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        tpg_clear_d = (state_d == S_CLEAR);
        test_sel_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_RUN) ||
                      (state_d == S_DRAIN) || (state_d == S_COMPARE);
        done_d      = (state_d == S_DONE);

        pass_d = pass_q;
        if (state_d == S_DONE) begin
            if (state_q == S_COMPARE) begin
                pass_d = (sig_w == GOLDEN);
            end
        end else begin
            pass_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            tpg_clear_q <= 1'b1;
            test_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            tpg_clear_q <= tpg_clear_d;
            test_sel_q  <= test_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    bist_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clock  (clock),
        .reset  (reset),
        .clear  (misr_clear),
        .enable (cap_en),
        .din    (cut_response),
        .sig    (sig_w)
    );

    assign tpg_clear = tpg_clear_q;
    assign test_sel  = test_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_w;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: two instances (CUT latency 0 and 2) driven by a seeded generator.
module tb_bist_controller;

    localparam int NP = 7;

    function automatic logic [2:0] seq_at(input int k);
        case (k)
            0: return 3'b001;
            1: return 3'b110;
            2: return 3'b011;
            3: return 3'b111;
            4: return 3'b101;
            5: return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    // Signature arithmetic: multiply by x modulo x^3+x+1, then add the response.
    function automatic logic [2:0] sig_step(input logic [2:0] s, input logic [2:0] d);
        int v;
        v = int'(s) * 2;
        if (v >= 8) v = (v - 8) ^ 3;
        return 3'(v) ^ d;
    endfunction

    function automatic logic [2:0] model_golden();
        logic [2:0] s;
        s = 3'b000;
        for (int k = 0; k < NP; k++) s = sig_step(s, seq_at(k));
        return s;
    endfunction

    localparam logic [2:0] GOLDEN = model_golden();

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_s [2];
    logic       abort_s [2];
    logic [2:0] g [2];
    logic [3:0] p [2];
    logic [2:0] cut_w [2];
    logic [2:0] d1, d2;
    logic [2:0] err_m [0:15];

    logic       tpg_clear_w [2];
    logic       test_sel_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       pass_w [2];
    logic [2:0] sig_w [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bist_controller #(.WIDTH(3), .N_PATTERNS(NP), .CUT_LAT(0), .POLY(3'b011), .GOLDEN(GOLDEN)) u_dut0 (
        .clock(clk), .reset(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .tpg_data(g[0]), .cut_response(cut_w[0]), .tpg_clear(tpg_clear_w[0]),
        .test_sel(test_sel_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .signature(sig_w[0]));

    bist_controller #(.WIDTH(3), .N_PATTERNS(NP), .CUT_LAT(2), .POLY(3'b011), .GOLDEN(GOLDEN)) u_dut1 (
        .clock(clk), .reset(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .tpg_data(g[1]), .cut_response(cut_w[1]), .tpg_clear(tpg_clear_w[1]),
        .test_sel(test_sel_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .signature(sig_w[1]));

    // Pattern generator (seed 001) and CUT stand-ins: plain loopback, and a 2-stage delayed loopback.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tpg_clear_w[i]) begin
                g[i] <= 3'b001;
                p[i] <= 4'd0;
            end else begin
                g[i] <= {1'b0, g[i][2:1]} ^ (g[i][0] ? 3'b110 : 3'b000);
                if (p[i] != 4'hf) p[i] <= p[i] + 4'd1;
            end
        end
        d1 <= g[1] ^ err_m[p[1]];
        d2 <= d1;
    end

    assign cut_w[0] = g[0] ^ err_m[p[0]];
    assign cut_w[1] = d2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input int sel, input logic exp_clear);
        check_val("idle_busy", busy_w[sel], 0);
        check_val("idle_test_sel", test_sel_w[sel], 0);
        check_val("idle_done", done_w[sel], 0);
        check_val("idle_pass", pass_w[sel], 0);
        check_val("idle_tpg_clear", tpg_clear_w[sel], exp_clear);
    endtask

    // Called at a falling edge; start is sampled at the next rising edge (cycle offset 0).
    task automatic do_run(input int sel, input int abort_off, input int spur_off);
        int         lat;
        int         dn;
        logic [2:0] exp_sig;
        logic       exp_pass;
        lat = (sel == 1) ? 2 : 0;
        dn  = NP + lat + 3;
        exp_sig = 3'b000;
        for (int k = 0; k < NP; k++) exp_sig = sig_step(exp_sig, seq_at(k) ^ err_m[k]);
        exp_pass = (exp_sig == GOLDEN);
        start_s[sel] = 1'b1;
        for (int off = 1; off <= dn; off++) begin
            @(negedge clk);
            start_s[sel] = (off == spur_off);
            check_val("busy", busy_w[sel], (off < dn));
            check_val("test_sel", test_sel_w[sel], (off >= 2 && off <= NP + 1 + lat));
            check_val("tpg_clear", tpg_clear_w[sel], (off == 1));
            check_val("done", done_w[sel], (off == dn));
            if (off == abort_off) begin
                abort_s[sel] = 1'b1;
                @(negedge clk);
                abort_s[sel] = 1'b0;
                start_s[sel] = 1'b0;
                check_idle(sel, 1'b0);
                return;
            end
        end
        check_val("signature", sig_w[sel], exp_sig);
        check_val("pass", pass_w[sel], exp_pass);
        repeat (3) begin
            @(negedge clk);
            check_val("hold_done", done_w[sel], 1);
            check_val("hold_sig", sig_w[sel], exp_sig);
            check_val("hold_pass", pass_w[sel], exp_pass);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, spur, ab, lat;
        for (int k = 0; k < 16; k++) err_m[k] = 3'b000;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
        end

        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_idle(i, 1'b1);
            check_val("rst_sig", sig_w[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("clear_after_release", tpg_clear_w[0], 1);
        @(negedge clk);
        check_idle(0, 1'b0);
        check_idle(1, 1'b0);

        do_run(0, -1, -1);                          // plain loopback
        err_m[3] = 3'b001;
        do_run(0, -1, -1);                          // one corrupted response
        check_val("sig_differs", (sig_w[0] != GOLDEN), 1);
        err_m[3] = 3'b000;
        do_run(1, -1, -1);                          // latency-2 loopback
        do_run(0, -1, 4);                           // start pulse while running
        do_run(0, 5, -1);                           // abort in fourth RUN cycle
        do_run(0, -1, -1);

        // abort and start together while DONE: abort must win
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check_idle(0, 1'b0);

        repeat (10) begin
            sel  = int'($urandom_range(0, 1));
            lat  = (sel == 1) ? 2 : 0;
            for (int k = 0; k < NP; k++)
                err_m[k] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            spur = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NP + lat + 2)) : -1;
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NP + lat + 2)) : -1;
            do_run(sel, ab, spur);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int k = 0; k < 16; k++) err_m[k] = 3'b000;

        // reset during DRAIN on the latency-2 instance
        start_s[1] = 1'b1;
        repeat (9) begin
            @(negedge clk);
            start_s[1] = 1'b0;
        end
        check_val("drain_test_sel", test_sel_w[1], 1);
        check_val("drain_busy", busy_w[1], 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle(1, 1'b1);
        check_val("rst_drain_sig", sig_w[1], 0);
        @(negedge clk);
        check_val("rst_held_clear", tpg_clear_w[1], 1);
        rst_n = 1'b1;
        #1 check_val("rst_release_clear", tpg_clear_w[1], 1);
        @(negedge clk);
        check_idle(1, 1'b0);
        do_run(1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter WIDTH, default 3: pattern and response width in bits.
REQ-002 Parameter N_PATTERNS, default 7: number of patterns applied per run; legal range 1..255.
REQ-003 Parameter CUT_LAT, default 0: circuit-under-test (CUT) response latency in clocks; legal range 0..3.
REQ-004 Parameter POLY, default 3'b011: MISR feedback tap mask; same polynomial as the 3-bit pattern generator, x^3+x+1.
REQ-005 Parameter GOLDEN, default 0: expected signature.
REQ-006 clock  in  1  — single clock; all state updates on its rising edge.
REQ-007 reset  in  1  — asynchronous, active-low reset.
REQ-008 start  in  1  — request a self-test run; sampled in IDLE and DONE only.
REQ-009 abort  in  1  — synchronous abort; returns the block to IDLE.
REQ-010 tpg_data  in  WIDTH  — current pattern from the pattern generator.
REQ-011 cut_response  in  WIDTH  — CUT output.
REQ-012 tpg_clear  out  1  — active-high clear to the pattern generator; reloads its seed.
REQ-013 test_sel  out  1  — 1 selects tpg_data into the CUT instead of functional inputs.
REQ-014 busy  out  1  — high in CLEAR, RUN, DRAIN and COMPARE.
REQ-015 done  out  1  — high in DONE.
REQ-016 pass  out  1  — valid while done=1: 1 means signature==GOLDEN.
REQ-017 signature  out  WIDTH  — current MISR contents.

Function
REQ-018 States SHALL be IDLE, CLEAR, RUN, DRAIN, COMPARE and DONE.
REQ-019 IDLE/DONE, start=1 -> CLEAR.
REQ-020 CLEAR lasts 1 cycle: tpg_clear=1, MISR cleared to 0, pattern counter cleared to 0.
REQ-021 RUN lasts exactly N_PATTERNS cycles: test_sel=1, pattern counter increments every cycle; counter==N_PATTERNS-1 -> DRAIN, or COMPARE when CUT_LAT=0.
REQ-022 DRAIN lasts CUT_LAT cycles: test_sel=1 and the pattern counter holds.
REQ-023 MISR capture SHALL be enabled on exactly N_PATTERNS cycles, starting CUT_LAT cycles after the first RUN cycle.
REQ-024 MISR update: shift with feedback from the MSB through POLY, then XOR with cut_response, bitwise.
REQ-025 COMPARE lasts 1 cycle: pass is registered as (signature==GOLDEN), then the block moves to DONE.
REQ-026 DONE holds done=1, pass and signature stable until start or abort.
REQ-027 start=1 while busy SHALL be ignored and SHALL NOT restart the run.
REQ-028 abort=1 in any state -> IDLE next cycle: test_sel=0, done=0, pass=0; abort wins over a simultaneous start.
REQ-029 Latency: start sampled at cycle t gives done=1 at cycle t+N_PATTERNS+CUT_LAT+3.
REQ-030 The pattern counter width is clog2(N_PATTERNS+1) and it SHALL never wrap within a run.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE and set tpg_clear=1, test_sel=0, busy=0, done=0, pass=0, signature=0 and pattern counter=0.
REQ-032 tpg_clear SHALL follow reset asynchronously and deassert on the first clock after reset release.
REQ-033 Reset asserted mid-run SHALL discard all results; there is no resume.

Structure
REQ-034 Shared package bist_pkg SHALL hold the state enum, the default POLY and the default seed (3'b001).
REQ-035 The MISR SHALL be a separate sub-module, bist_misr, with ports clock, reset, clear, enable, din and sig.
REQ-036 All outputs SHALL be registered; the only exception is tpg_clear's asynchronous assertion during reset.

Verification
REQ-037 Loopback (cut_response=tpg_data, generator seeded 001), GOLDEN taken from the model -> tpg_data sequence 001,110,011,111,101,100,010; done at t+10; pass=1.
REQ-038 Same run with cut_response bit 0 inverted on pattern 3 -> pass=0 and signature differs from GOLDEN.
REQ-039 CUT_LAT=2 with a 2-stage delayed loopback -> pass=1 with the same signature as REQ-037; done at t+12.
REQ-040 start pulsed during RUN -> no restart; done at t+10 unchanged.
REQ-041 abort asserted in RUN cycle 4 -> IDLE next cycle, test_sel=0, done=0; a following start completes with pass=1.
REQ-042 reset asserted in DRAIN -> all outputs at reset values immediately; tpg_clear=1 until the first clock after release.
